row_buffer_ring: RTL and testbench
==================================

# row_buffer_ring

Parametrised successor of the two-row ping-pong download buffer. It replaces the fixed A/B swap with a ring of NUM_ROWS row buffers, and owns an explicit commit/release handshake on each side, per-row length tags, occupancy count and sticky error flags. It sits in the memory clock domain between the SDRAM read engine and the row-to-LCD CDC stage. The writer fills rows and the reader drains them strictly in FIFO order.

## Interface
- DATA_WIDTH, 16: pixel word width.
- ADDR_WIDTH, 11: in-row address width; row depth = 2^ADDR_WIDTH words.
- NUM_ROWS, 4: rows in the ring; legal range 2..8. RW = $clog2(NUM_ROWS), CW = $clog2(NUM_ROWS+1).

- clk_mem  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- init  in  1  synchronous soft clear; same effect as reset except that RAM contents are not touched.
- wr_addr  in  ADDR_WIDTH  word address within the current write row.
- wr_data  in  DATA_WIDTH  word to write.
- wr_en  in  1  write strobe.
- wr_len  in  ADDR_WIDTH+1  valid word count of the row being committed (0..2^ADDR_WIDTH).
- wr_commit_valid  in  1  writer hands the current row to the reader.
- wr_commit_ready  out  1  high when count < NUM_ROWS.
- rows_free  out  CW  NUM_ROWS - count.
- rd_addr  in  ADDR_WIDTH  word address within the current read row.
- rd_en  in  1  read strobe.
- rd_data  out  DATA_WIDTH  read word.
- rd_data_valid  out  1  rd_data is valid this cycle.
- rd_row_len  out  ADDR_WIDTH+1  wr_len captured for the current read row.
- row_available  out  1  count > 0.
- rd_release_valid  in  1  reader is finished with the current row.
- rd_release_ready  out  1  equals row_available.
- overflow  out  1  sticky: a write or commit was attempted while full.
- underflow  out  1  sticky: a read or release was attempted while empty.

## Operation
- Storage: one inferred RAM of NUM_ROWS × 2^ADDR_WIDTH words. The physical address is {row, addr}. The read port is synchronous.
- State: wr_ptr, rd_ptr (RW bits each, wrapping at NUM_ROWS-1 → 0, correct for non-power-of-2 NUM_ROWS), count (CW bits), len[NUM_ROWS], rd_data_valid, overflow, underflow.
- Write: wr_en && count < NUM_ROWS writes wr_data to {wr_ptr, wr_addr}. wr_en while full is dropped and sets overflow.
- Commit handshake fires when wr_commit_valid && wr_commit_ready. It then does len[wr_ptr] <= wr_len, advances wr_ptr, and increments count. wr_commit_valid while full does not fire and sets overflow.
- Read: rd_en && count > 0 reads {rd_ptr, rd_addr}. rd_en while empty sets underflow, produces no read, and leaves rd_data at its old value.
- Release handshake fires when rd_release_valid && rd_release_ready. It then advances rd_ptr and decrements count.
- Commit and release in the same cycle: both pointers advance and count is unchanged.
- A write and a commit in the same cycle: the word lands in the row being committed.
- A read and a release in the same cycle: the read samples the row being released. Its data is returned next cycle with rd_data_valid = 1.
- rd_row_len = len[rd_ptr], combinational from registers. It is 0 when empty.
- overflow and underflow clear only on reset or init.
- Reset or init, synchronous, takes priority over all strobes in that cycle:
  - clears wr_ptr, rd_ptr, count, all len entries, rd_data_valid, overflow and underflow;
  - rd_data resets to 0 on reset only and keeps its value on init;
  - any read in flight is discarded (rd_data_valid = 0 next cycle).

## Timing
- Values during and after reset: wr_commit_ready = 1, rows_free = NUM_ROWS, row_available = 0, rd_release_ready = 0, rd_data_valid = 0, rd_data = 0, rd_row_len = 0, overflow = 0, underflow = 0.
- Read latency: 1 cycle from the rd_en edge to rd_data / rd_data_valid. Back-to-back reads give one word per cycle.
- Commit to read: row_available rises on the cycle after the commit edge. The earliest rd_en is that cycle, so the earliest data comes one cycle later.
- Release to write: wr_commit_ready / rows_free update on the cycle after the release edge. The freed row becomes writable once wr_ptr reaches it.
- Handshake outputs depend only on registered count. There is no combinational path from valid inputs to ready outputs.

## Test plan
- Reset, then NUM_ROWS=4 idle → wr_commit_ready=1, rows_free=4, row_available=0, all flags 0.
- Write addr 0..7 with data 0x100+addr, commit with wr_len=8, read addr 0..7 → row_available=1 one cycle after commit, rd_row_len=8, rd_data=0x100..0x107 each one cycle after rd_en, release → row_available=0.
- Commit 4 rows with distinct data, then a fifth wr_en and commit → wr_commit_ready=0, rows_free=0, overflow=1, row 0 data intact; release once → rows_free=1 the next cycle.
- NUM_ROWS=3: run 10 commit/release cycles → pointers wrap 2→0, every row reads back its own pattern and wr_len.
- Commit and release in the same cycle with count=2 → count stays 2; read with release in the same cycle returns the released row's word next cycle.
- rd_en and release while empty → underflow=1, rd_data_valid=0; init mid-stream with count=3 → count=0 and flags clear the next cycle, rd_data_valid drops, and a subsequent write/commit/read works from row 0.

Source files
------------

// File: rtl/row_buffer_ring.sv
// Ring of NUM_ROWS row buffers between the SDRAM read engine and the row-to-LCD CDC stage.
// Rows are filled by the writer and drained by the reader in FIFO order via commit/release handshakes.
module row_buffer_ring #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned NUM_ROWS   = 4
) (
    input  logic                                 clk_mem,
    input  logic                                 reset_n,
    input  logic                                 init,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH:0]                  wr_len,
    input  logic                                 wr_commit_valid,
    output logic                                 wr_commit_ready,
    output logic [$clog2(NUM_ROWS+1)-1:0]        rows_free,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_data_valid,
    output logic [ADDR_WIDTH:0]                  rd_row_len,
    output logic                                 row_available,
    input  logic                                 rd_release_valid,
    output logic                                 rd_release_ready,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int unsigned RW    = $clog2(NUM_ROWS);
    localparam int unsigned CW    = $clog2(NUM_ROWS + 1);
    localparam int unsigned DEPTH = NUM_ROWS << ADDR_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(NUM_ROWS);
    localparam logic [RW-1:0] LAST = RW'(NUM_ROWS - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [RW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q [NUM_ROWS];
    logic                  rd_valid_q;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic full, empty, clr;
    logic wr_fire, rd_fire, commit_fire, release_fire;

    // Explicit wrap keeps the ring correct when NUM_ROWS is not a power of two.
    function automatic logic [RW-1:0] ptr_next(input logic [RW-1:0] p);
        return (p == LAST) ? '0 : p + RW'(1);
    endfunction

    assign clr          = !reset_n || init;
    assign full         = (count_q == FULL);
    assign empty        = (count_q == '0);
    assign wr_fire      = wr_en && !full && !clr;
    assign rd_fire      = rd_en && !empty && !clr;
    assign commit_fire  = wr_commit_valid && !full;
    assign release_fire = rd_release_valid && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || ((wr_en || wr_commit_valid) && full);
        unf_d    = unf_q || ((rd_en || rd_release_valid) && empty);
        if (commit_fire) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (release_fire) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({commit_fire, release_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_mem) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_fire;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            if (commit_fire) begin
                len_q[wr_ptr_q] <= wr_len;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM; init leaves contents untouched.
    always_ff @(posedge clk_mem) begin
        if (wr_fire) begin
            mem[{wr_ptr_q, wr_addr}] <= wr_data;
        end
    end

    // Read register clears on hard reset only; init merely blocks the read.
    always_ff @(posedge clk_mem) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= mem[{rd_ptr_q, rd_addr}];
        end
    end

    assign wr_commit_ready  = !full;
    assign rows_free        = FULL - count_q;
    assign row_available    = !empty;
    assign rd_release_ready = !empty;
    assign rd_data          = rd_data_q;
    assign rd_data_valid    = rd_valid_q;
    assign rd_row_len       = empty ? '0 : len_q[rd_ptr_q];
    assign overflow         = ovf_q;
    assign underflow        = unf_q;

endmodule

// File: tb/tb_row_buffer_ring.sv
// Scoreboard bench for row_buffer_ring: a 4-row instance at default widths and a 3-row instance
// exercising pointer wrap on a non-power-of-two ring.
module tb_row_buffer_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic reset_n = 1'b0;

    // ---- 4-row instance, default widths
    logic        init = 0, we = 0, cv = 0, re = 0, rv = 0;
    logic [10:0] wa = '0, ra = '0;
    logic [15:0] wd = '0;
    logic [11:0] wl = '0;
    logic        c_ready, d_valid, r_avail, r_ready, ovf, unf;
    logic [2:0]  r_free;
    logic [15:0] d_out;
    logic [11:0] r_len;
    logic [15:0] sb4[$];

    row_buffer_ring #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .NUM_ROWS(4)) u_dut (
        .clk_mem(clk), .reset_n(reset_n), .init(init),
        .wr_addr(wa), .wr_data(wd), .wr_en(we), .wr_len(wl),
        .wr_commit_valid(cv), .wr_commit_ready(c_ready), .rows_free(r_free),
        .rd_addr(ra), .rd_en(re), .rd_data(d_out), .rd_data_valid(d_valid),
        .rd_row_len(r_len), .row_available(r_avail),
        .rd_release_valid(rv), .rd_release_ready(r_ready),
        .overflow(ovf), .underflow(unf)
    );

    // ---- 3-row instance, narrow rows
    logic        t_init = 0, t_we = 0, t_cv = 0, t_re = 0, t_rv = 0;
    logic [3:0]  t_wa = '0, t_ra = '0;
    logic [15:0] t_wd = '0;
    logic [4:0]  t_wl = '0;
    logic        t_c_ready, t_d_valid, t_r_avail, t_r_ready, t_ovf, t_unf;
    logic [1:0]  t_r_free;
    logic [15:0] t_d_out;
    logic [4:0]  t_r_len;
    logic [15:0] sb3[$];

    row_buffer_ring #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_ROWS(3)) u_dut3 (
        .clk_mem(clk), .reset_n(reset_n), .init(t_init),
        .wr_addr(t_wa), .wr_data(t_wd), .wr_en(t_we), .wr_len(t_wl),
        .wr_commit_valid(t_cv), .wr_commit_ready(t_c_ready), .rows_free(t_r_free),
        .rd_addr(t_ra), .rd_en(t_re), .rd_data(t_d_out), .rd_data_valid(t_d_valid),
        .rd_row_len(t_r_len), .row_available(t_r_avail),
        .rd_release_valid(t_rv), .rd_release_ready(t_r_ready),
        .overflow(t_ovf), .underflow(t_unf)
    );

    // Scoreboard monitors: every valid word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (d_valid) begin
            if (sb4.size() == 0) check("rd4_spurious_valid", 32'd1, 32'd0);
            else check("rd4_data", {16'd0, d_out}, {16'd0, sb4.pop_front()});
        end
        if (t_d_valid) begin
            if (sb3.size() == 0) check("rd3_spurious_valid", 32'd1, 32'd0);
            else check("rd3_data", {16'd0, t_d_out}, {16'd0, sb3.pop_front()});
        end
    end

    task automatic step4(input logic we_i, input logic [10:0] wa_i, input logic [15:0] wd_i,
                         input logic cv_i, input logic [11:0] wl_i, input logic re_i,
                         input logic [10:0] ra_i, input logic rv_i, input logic ini_i);
        we = we_i; wa = wa_i; wd = wd_i; cv = cv_i; wl = wl_i;
        re = re_i; ra = ra_i; rv = rv_i; init = ini_i;
        @(negedge clk);
        we = 0; cv = 0; re = 0; rv = 0; init = 0;
    endtask

    task automatic write4(input int a, input int d);
        step4(1'b1, 11'(a), 16'(d), 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask
    task automatic commit4(input int l);
        step4(1'b0, '0, '0, 1'b1, 12'(l), 1'b0, '0, 1'b0, 1'b0);
    endtask
    task automatic read4(input int a, input int exp);
        sb4.push_back(16'(exp));
        step4(1'b0, '0, '0, 1'b0, '0, 1'b1, 11'(a), 1'b0, 1'b0);
    endtask
    task automatic release4();
        step4(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic step3(input logic we_i, input int a, input int d, input logic cv_i,
                         input int l, input logic re_i, input logic rv_i);
        t_we = we_i; t_wa = 4'(a); t_wd = 16'(d); t_cv = cv_i; t_wl = 5'(l);
        t_re = re_i; t_ra = 4'(a); t_rv = rv_i;
        @(negedge clk);
        t_we = 0; t_cv = 0; t_re = 0; t_rv = 0;
    endtask

    function automatic int pat3(input int i, input int a);
        return 32'h500 + i * 16 + a;
    endfunction

    task automatic fill3(input int i);
        for (int a = 0; a < 3; a++) step3(1'b1, a, pat3(i, a), 1'b0, 0, 1'b0, 1'b0);
        step3(1'b0, 0, 0, 1'b1, i + 1, 1'b0, 1'b0);
    endtask

    task automatic drain3(input int i);
        check("r3_row_len", {27'd0, t_r_len}, 32'(i + 1));
        for (int a = 0; a < 3; a++) begin
            sb3.push_back(16'(pat3(i, a)));
            step3(1'b0, a, 0, 1'b0, 0, 1'b1, 1'b0);
        end
        step3(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset: values hold during and after reset
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, c_ready}, 32'd1);
        check("rst_free", {29'd0, r_free}, 32'd4);
        check("rst_avail", {31'd0, r_avail}, 32'd0);
        check("rst_rdata", {16'd0, d_out}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_free", {29'd0, r_free}, 32'd4);
        check("idle_rel_ready", {31'd0, r_ready}, 32'd0);
        check("idle_len", {20'd0, r_len}, 32'd0);
        check("idle_flags", {30'd0, ovf, unf}, 32'd0);
        check("idle_valid", {31'd0, d_valid}, 32'd0);

        // Single row round trip
        for (int a = 0; a < 8; a++) write4(a, 32'h100 + a);
        commit4(8);
        check("t2_avail", {31'd0, r_avail}, 32'd1);
        check("t2_len", {20'd0, r_len}, 32'd8);
        check("t2_free", {29'd0, r_free}, 32'd3);
        for (int a = 0; a < 8; a++) read4(a, 32'h100 + a);
        release4();
        check("t2_avail_after_rel", {31'd0, r_avail}, 32'd0);
        check("t2_free_after_rel", {29'd0, r_free}, 32'd4);

        // Fill the ring, then attempt a fifth write+commit
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 4; a++) write4(a, 32'h200 + r * 16 + a);
            commit4(r + 1);
        end
        check("t3_ready_full", {31'd0, c_ready}, 32'd0);
        check("t3_free_full", {29'd0, r_free}, 32'd0);
        check("t3_ovf_before", {31'd0, ovf}, 32'd0);
        step4(1'b1, '0, 16'hDEAD, 1'b1, 12'd9, 1'b0, '0, 1'b0, 1'b0);
        check("t3_ovf", {31'd0, ovf}, 32'd1);
        check("t3_free_still0", {29'd0, r_free}, 32'd0);
        check("t3_head_len", {20'd0, r_len}, 32'd1);
        for (int a = 0; a < 4; a++) read4(a, 32'h200 + a);
        release4();
        check("t3_free_after_rel", {29'd0, r_free}, 32'd1);
        check("t3_ready_after_rel", {31'd0, c_ready}, 32'd1);
        for (int r = 1; r < 3; r++) begin
            check("t3_len", {20'd0, r_len}, 32'(r + 1));
            for (int a = 0; a < 4; a++) read4(a, 32'h200 + r * 16 + a);
            release4();
        end

        // Commit+release, write+commit and read+release all in one cycle at count=2
        for (int a = 0; a < 4; a++) write4(a, 32'h300 + a);
        commit4(5);
        check("t5_free_pre", {29'd0, r_free}, 32'd2);
        sb4.push_back(16'h233);
        step4(1'b1, '0, 16'h3A0, 1'b1, 12'd6, 1'b1, 11'd3, 1'b1, 1'b0);
        check("t5_free_same", {29'd0, r_free}, 32'd2);
        check("t5_avail", {31'd0, r_avail}, 32'd1);
        check("t5_len_next", {20'd0, r_len}, 32'd5);
        for (int a = 0; a < 4; a++) read4(a, 32'h300 + a);
        release4();
        check("t5_len_last", {20'd0, r_len}, 32'd6);
        read4(0, 32'h3A0);
        release4();
        check("t5_empty", {31'd0, r_avail}, 32'd0);
        check("t5_free4", {29'd0, r_free}, 32'd4);
        check("t5_ovf_sticky", {31'd0, ovf}, 32'd1);
        check("t5_unf_clear", {31'd0, unf}, 32'd0);

        // Underflow on empty ring
        step4(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);
        check("t6_unf", {31'd0, unf}, 32'd1);
        check("t6_valid_low", {31'd0, d_valid}, 32'd0);
        check("t6_rdata_held", {16'd0, d_out}, 32'h3A0);
        check("t6_free", {29'd0, r_free}, 32'd4);

        // Init mid-stream with three rows queued and a read issued in the init cycle
        for (int r = 0; r < 3; r++) begin
            write4(0, 32'h600 + r);
            commit4(1);
        end
        check("t6_free_pre_init", {29'd0, r_free}, 32'd1);
        read4(0, 32'h600);
        step4(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        check("init_free", {29'd0, r_free}, 32'd4);
        check("init_avail", {31'd0, r_avail}, 32'd0);
        check("init_flags", {30'd0, ovf, unf}, 32'd0);
        check("init_valid", {31'd0, d_valid}, 32'd0);
        check("init_rdata_kept", {16'd0, d_out}, 32'h600);
        check("init_len", {20'd0, r_len}, 32'd0);
        write4(2, 32'h4AA);
        commit4(3);
        check("post_init_len", {20'd0, r_len}, 32'd3);
        read4(2, 32'h4AA);
        release4();
        check("post_init_free", {29'd0, r_free}, 32'd4);

        // 3-row ring: keep it full while cycling thirteen rows through
        for (int i = 0; i < 3; i++) fill3(i);
        check("r3_ready_full", {31'd0, t_c_ready}, 32'd0);
        check("r3_free_full", {30'd0, t_r_free}, 32'd0);
        for (int i = 3; i < 13; i++) begin
            drain3(i - 3);
            fill3(i);
        end
        for (int i = 10; i < 13; i++) drain3(i);
        check("r3_empty", {31'd0, t_r_avail}, 32'd0);
        check("r3_free", {30'd0, t_r_free}, 32'd3);
        check("r3_flags", {30'd0, t_ovf, t_unf}, 32'd0);

        repeat (2) @(negedge clk);
        check("sb4_drained", 32'(sb4.size()), 32'd0);
        check("sb3_drained", 32'(sb3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
